div_result_bcd: RTL and testbench

//  Downstream stage of the sequential divider. Captures quotient/remainder on the rising

---
 rtl/div_result_bcd.sv | 114 +++++++++++
 tb/tb_div_result_bcd.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/div_result_bcd.sv
// div_result_bcd: captures divider quotient/remainder on ready_in rise and converts to packed BCD
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-high reset
//   ready_in  in   divider ready level; rising edge marks a new result
//   qu_in     in   quotient (QW bits), rem_in remainder (RW bits)
//   busy      out  high while converting
//   out_valid out  BCD result valid, held until out_ack
//   out_ack   in   consumer accepts result (only honoured while out_valid)
//   qu_bcd    out  packed BCD quotient (QD digits, digit 0 in [3:0])
//   rem_bcd   out  packed BCD remainder (RD digits)
//   overrun   out  sticky: a result edge arrived while not idle and was dropped
module div_result_bcd #(
    parameter int QW = 8,
    parameter int RW = 4,
    parameter int QD = 3,
    parameter int RD = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ready_in,
    input  logic [QW-1:0]   qu_in,
    input  logic [RW-1:0]   rem_in,
    output logic            busy,
    output logic            out_valid,
    input  logic            out_ack,
    output logic [4*QD-1:0] qu_bcd,
    output logic [4*RD-1:0] rem_bcd,
    output logic            overrun
);
    typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;
    localparam int CW  = $clog2(QW + 1);
    localparam int RCW = $clog2(RW + 1);

    state_t          state;
    logic            ready_d;
    logic [QW-1:0]   qsh;
    logic [RW-1:0]   rsh;
    logic [4*QD-1:0] qacc, qadj, qacc_n;
    logic [4*RD-1:0] racc, radj, racc_n;
    logic [CW-1:0]   cnt;
    logic [RCW-1:0]  rcnt;
    logic            rise;

    assign rise = ready_in & ~ready_d;

    // One double-dabble step: add 3 to every digit >= 5, then shift in the next binary bit.
    // The remainder finishes first and stays frozen once its own count runs out.
    always_comb begin
        qadj = qacc;
        radj = racc;
        for (int i = 0; i < QD; i++)
            qadj[4*i +: 4] = qacc[4*i +: 4] >= 4'd5 ? qacc[4*i +: 4] + 4'd3 : qacc[4*i +: 4];
        for (int i = 0; i < RD; i++)
            radj[4*i +: 4] = racc[4*i +: 4] >= 4'd5 ? racc[4*i +: 4] + 4'd3 : racc[4*i +: 4];
        qacc_n = {qadj[4*QD-2:0], qsh[QW-1]};
        racc_n = rcnt != '0 ? {radj[4*RD-2:0], rsh[RW-1]} : racc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ready_d   <= 1'b0;
            qsh       <= '0;
            rsh       <= '0;
            qacc      <= '0;
            racc      <= '0;
            cnt       <= '0;
            rcnt      <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            qu_bcd    <= '0;
            rem_bcd   <= '0;
            overrun   <= 1'b0;
        end else begin
            ready_d <= ready_in;
            if (rise && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (rise) begin
                    qsh   <= qu_in;
                    rsh   <= rem_in;
                    qacc  <= '0;
                    racc  <= '0;
                    cnt   <= CW'(QW);
                    rcnt  <= RCW'(RW);
                    busy  <= 1'b1;
                    state <= CONV;
                end
                CONV: begin
                    qacc <= qacc_n;
                    qsh  <= qsh << 1;
                    racc <= racc_n;
                    if (rcnt != '0) begin
                        rsh  <= rsh << 1;
                        rcnt <= rcnt - 1'b1;
                    end
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        qu_bcd    <= qacc_n;
                        rem_bcd   <= racc_n;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= HOLD;
                    end
                end
                HOLD: if (out_ack) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_result_bcd.sv
// tb_div_result_bcd: directed vector and corner-sequence bench for div_result_bcd
module tb_div_result_bcd;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ready_in = 1'b0;
    logic [7:0]  qu_in = '0;
    logic [3:0]  rem_in = '0;
    logic        busy, out_valid, overrun;
    logic        out_ack = 1'b0;
    logic [11:0] qu_bcd;
    logic [7:0]  rem_bcd;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [7:0]  q;
        logic [3:0]  r;
        logic [11:0] eq;
        logic [7:0]  er;
    } vec_t;

    div_result_bcd dut (
        .clk(clk), .rst(rst), .ready_in(ready_in), .qu_in(qu_in), .rem_in(rem_in),
        .busy(busy), .out_valid(out_valid), .out_ack(out_ack),
        .qu_bcd(qu_bcd), .rem_bcd(rem_bcd), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Guarantees ready_in low for one edge, then raises it; returns just after the load edge.
    task automatic start(input logic [7:0] q, input logic [3:0] r);
        @(negedge clk);
        ready_in = 1'b0;
        @(negedge clk);
        qu_in = q;
        rem_in = r;
        ready_in = 1'b1;
        @(posedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!out_valid && n < 20);
    endtask

    task automatic ack();
        @(negedge clk);
        ready_in = 1'b0;
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("ack_drops_valid", out_valid, 0);
        @(negedge clk);
        out_ack = 1'b0;
    endtask

    task automatic conv(input vec_t v);
        int n;
        start(v.q, v.r);
        repeat (7) @(posedge clk);
        #1;
        chk("busy_mid", busy, 1);
        chk("valid_early", out_valid, 0);
        wait_valid(n);
        chk("latency", n, 1);
        chk("qu_bcd", qu_bcd, v.eq);
        chk("rem_bcd", rem_bcd, v.er);
        chk("busy_hold", busy, 0);
        ack();
    endtask

    initial begin
        vec_t vecs[6];
        int n;
        vecs[0] = '{8'd7,   4'd5,  12'h007, 8'h05};
        vecs[1] = '{8'd255, 4'd15, 12'h255, 8'h15};
        vecs[2] = '{8'd0,   4'd0,  12'h000, 8'h00};
        vecs[3] = '{8'd100, 4'd9,  12'h100, 8'h09};
        vecs[4] = '{8'd42,  4'd3,  12'h042, 8'h03};
        vecs[5] = '{8'd99,  4'd12, 12'h099, 8'h12};

        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_qu", qu_bcd, 0);
        chk("rst_rem", rem_bcd, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) conv(vecs[i]);

        // ready_in held high: one conversion, stable result until ack
        start(8'd7, 4'd5);
        repeat (40) @(posedge clk);
        #1;
        chk("hold_valid", out_valid, 1);
        chk("hold_qu", qu_bcd, 12'h007);
        chk("hold_rem", rem_bcd, 8'h05);
        chk("hold_overrun", overrun, 0);
        @(negedge clk);
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_ack", out_valid, 0);
        @(negedge clk);
        out_ack = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_no_retrigger", busy | out_valid, 0);

        // second rise during conversion is dropped
        start(8'd7, 4'd5);
        fork
            wait_valid(n);
            begin
                repeat (2) @(negedge clk);
                ready_in = 1'b0;
                @(negedge clk);
                qu_in = 8'd99;
                rem_in = 4'd1;
                ready_in = 1'b1;
            end
        join
        chk("ovr_latency", n, 8);
        chk("ovr_flag", overrun, 1);
        chk("ovr_qu", qu_bcd, 12'h007);
        chk("ovr_rem", rem_bcd, 8'h05);
        ack();
        repeat (3) @(posedge clk);
        #1;
        chk("ovr_sticky", overrun, 1);

        // reset mid-conversion
        start(8'd200, 4'd1);
        repeat (4) @(posedge clk);
        #3;
        rst = 1'b1;
        ready_in = 1'b0;
        #1;
        chk("mid_rst_qu", qu_bcd, 0);
        chk("mid_rst_rem", rem_bcd, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_overrun", overrun, 0);
        @(negedge clk);
        rst = 1'b0;
        conv(vecs[4]);

        // ack outside HOLD ignored; ack and rise together in HOLD
        @(negedge clk);
        out_ack = 1'b1;
        @(negedge clk);
        out_ack = 1'b0;
        chk("idle_ack_busy", busy, 0);
        start(8'd100, 4'd9);
        fork
            wait_valid(n);
            begin
                repeat (3) @(negedge clk);
                out_ack = 1'b1;
                @(negedge clk);
                out_ack = 1'b0;
            end
        join
        chk("conv_ack_latency", n, 8);
        chk("conv_ack_qu", qu_bcd, 12'h100);
        chk("pre_overrun", overrun, 0);
        @(negedge clk);
        ready_in = 1'b0;
        @(negedge clk);
        qu_in = 8'd1;
        ready_in = 1'b1;
        out_ack = 1'b1;
        @(posedge clk);
        #1;
        chk("same_valid", out_valid, 0);
        chk("same_overrun", overrun, 1);
        @(negedge clk);
        out_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("same_dropped", busy | out_valid, 0);
        chk("same_qu_kept", qu_bcd, 12'h100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
